inst_fetch_buffer: RTL and testbench

- Instruction-fetch stage directly downstream of the PC register.
- Takes each PC offered by the PC stage and issues it to instruction memory over a req/gnt/rvalid handshake.
- Queues returned instructions with their PCs in an in-order FIFO and presents them to decode with a valid/ready handshake.
- Provides back-pressure (stall) to the PC stage, and handles branch flush by dropping queued and in-flight fetches.

---
 rtl/inst_fetch_buffer_pkg.sv | 15 +
 rtl/inst_fetch_buffer_fifo.sv | 58 +++++
 rtl/inst_fetch_buffer.sv | 143 ++++++++++++++
 tb/tb_inst_fetch_buffer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_buffer_pkg.sv
// Shared widths, defaults and state encoding for the instruction fetch buffer.
package inst_fetch_buffer_pkg;

  localparam int unsigned InstAddrBus   = 32;
  localparam int unsigned InstBus       = 32;
  localparam logic        RstEnable     = 1'b1;
  localparam int unsigned FetchQDepth   = 4;
  localparam int unsigned FetchMaxOutst = 2;

  typedef enum logic {
    IfIdle = 1'b0,
    IfReq  = 1'b1
  } if_state_e;

endpackage

// File: rtl/inst_fetch_buffer_fifo.sv
// Synchronous FIFO with occupancy count and synchronous clear; output is zero while empty.
module inst_fetch_buffer_fifo
  import inst_fetch_buffer_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         push,
  input  logic [WIDTH-1:0]             din,
  input  logic                         pop,
  output logic [WIDTH-1:0]             dout,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;

  // Pointers wrap explicitly so non-power-of-two depths also work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Storage write; no reset needed since reads are gated by count.
  always_ff @(posedge clk) begin
    if (rst != RstEnable && !clr && push) begin
      mem[wptr] <= din;
    end
  end

  // Pointer and occupancy tracking, clear has priority over push/pop.
  always_ff @(posedge clk) begin
    if (rst == RstEnable || clr) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      assert (!(push && !pop && count == CW'(DEPTH)));
      assert (!(pop && count == '0));
      if (push) wptr <= ptr_inc(wptr);
      if (pop)  rptr <= ptr_inc(rptr);
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (!push && pop) begin
        count <= count - 1'b1;
      end
    end
  end

  assign dout = (count != '0) ? mem[rptr] : '0;

endmodule

// File: rtl/inst_fetch_buffer.sv
// Fetch stage: issues PCs to instruction memory, queues returned instructions for decode,
// back-pressures the PC stage and discards in-flight fetches on a branch flush.
module inst_fetch_buffer
  import inst_fetch_buffer_pkg::*;
#(
  parameter int unsigned DEPTH     = FetchQDepth,
  parameter int unsigned MAX_OUTST = FetchMaxOutst,
  parameter int unsigned AW        = InstAddrBus,
  parameter int unsigned DW        = InstBus
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] pc_i,
  input  logic          pc_ce_i,
  output logic          pc_stall_o,
  input  logic          flush_i,
  output logic          mem_req_o,
  output logic [AW-1:0] mem_addr_o,
  input  logic          mem_gnt_i,
  input  logic          mem_rvalid_i,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          id_valid_o,
  input  logic          id_ready_i,
  output logic [DW-1:0] id_inst_o,
  output logic [AW-1:0] id_pc_o
);

  localparam int unsigned QCW = $clog2(DEPTH + 1);
  localparam int unsigned OCW = $clog2(MAX_OUTST + 1);
  localparam int unsigned SW  = $clog2(DEPTH + MAX_OUTST + 2);

  if_state_e        state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [OCW-1:0]   drop_q, drop_d;
  logic [OCW-1:0]   outst;
  logic [QCW-1:0]   q_count;
  logic [SW-1:0]    credit_sum;
  logic [OCW:0]     slot_lhs, slot_rhs;
  logic             req_pending, slot_ok, credit_ok, can_latch;
  logic             q_push, q_pop;
  logic [AW-1:0]    resp_pc;
  logic [AW+DW-1:0] q_head;

  assign req_pending = (state_q == IfReq);

  // A PC latched in REQ rides on this cycle's grant, so the slot check sees that grant landing
  // and any response leaving now; this keeps the in-flight PC FIFO from overflowing.
  assign slot_lhs = {1'b0, outst} + {{OCW{1'b0}}, req_pending};
  assign slot_rhs = (OCW + 1)'(MAX_OUTST) + {{OCW{1'b0}}, req_pending & mem_rvalid_i};
  assign slot_ok  = slot_lhs < slot_rhs;

  assign credit_sum = SW'(q_count) + SW'(outst) + SW'(req_pending);
  assign credit_ok  = (credit_sum < SW'(DEPTH)) && slot_ok;
  assign can_latch  = credit_ok && !flush_i && (!req_pending || mem_gnt_i);
  assign pc_stall_o = pc_ce_i && !can_latch;

  assign mem_req_o  = req_pending;
  assign mem_addr_o = addr_q;

  // Issue FSM: latch a PC when idle, or back-to-back alongside a grant.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    unique case (state_q)
      IfIdle: begin
        if (pc_ce_i && can_latch) begin
          state_d = IfReq;
          addr_d  = pc_i & ~AW'(3);
        end
      end
      IfReq: begin
        if (mem_gnt_i) begin
          if (pc_ce_i && can_latch) begin
            addr_d = pc_i & ~AW'(3);
          end else begin
            state_d = IfIdle;
          end
        end
      end
      default: state_d = IfIdle;
    endcase
  end

  // Drop counter: on flush, count responses still to come (including an ungranted request).
  always_comb begin
    drop_d = drop_q;
    if (flush_i) begin
      drop_d = outst + OCW'(req_pending) - OCW'(mem_rvalid_i);
    end else if (mem_rvalid_i && drop_q != '0) begin
      drop_d = drop_q - 1'b1;
    end
  end

  // State, address and drop registers.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q <= IfIdle;
      addr_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      drop_q  <= drop_d;
    end
  end

  assign q_push     = mem_rvalid_i && !flush_i && (drop_q == '0);
  assign q_pop      = id_valid_o && id_ready_i && !flush_i;
  assign id_valid_o = (q_count != '0);

  // In-flight PCs, popped in order as responses return; occupancy is the outstanding count.
  inst_fetch_buffer_fifo #(
    .WIDTH (AW),
    .DEPTH (MAX_OUTST)
  ) u_pc_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .push  (req_pending & mem_gnt_i),
    .din   (addr_q),
    .pop   (mem_rvalid_i),
    .dout  (resp_pc),
    .count (outst)
  );

  inst_fetch_buffer_fifo #(
    .WIDTH (AW + DW),
    .DEPTH (DEPTH)
  ) u_inst_q (
    .clk   (clk),
    .rst   (rst),
    .clr   (flush_i),
    .push  (q_push),
    .din   ({resp_pc, mem_rdata_i}),
    .pop   (q_pop),
    .dout  (q_head),
    .count (q_count)
  );

  assign id_pc_o   = q_head[AW+DW-1:DW];
  assign id_inst_o = q_head[DW-1:0];

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Directed bench for inst_fetch_buffer with a small in-order memory responder.
module tb_inst_fetch_buffer;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        pc_ce;
  logic        pc_stall;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc;

  logic        gnt_en;
  logic        ret_en;
  logic [31:0] pend[$];
  int          checks = 0;
  int          errors = 0;
  int          n_del;
  logic [31:0] first_pc;

  inst_fetch_buffer dut (
    .clk          (clk),
    .rst          (rst),
    .pc_i         (pc),
    .pc_ce_i      (pc_ce),
    .pc_stall_o   (pc_stall),
    .flush_i      (flush),
    .mem_req_o    (mem_req),
    .mem_addr_o   (mem_addr),
    .mem_gnt_i    (mem_gnt),
    .mem_rvalid_i (mem_rvalid),
    .mem_rdata_i  (mem_rdata),
    .id_valid_o   (id_valid),
    .id_ready_i   (id_ready),
    .id_inst_o    (id_inst),
    .id_pc_o      (id_pc)
  );

  assign mem_gnt = mem_req & gnt_en;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic drive_mem();
    mem_rvalid = ret_en && (pend.size() > 0);
    mem_rdata  = (pend.size() > 0) ? inst_of(pend[0]) : 32'h0;
  endtask

  // One clock: sample handshakes before the edge, update the responder after it.
  task automatic tick();
    logic        g;
    logic        rv;
    logic [31:0] a;
    #1;
    g  = mem_req & mem_gnt;
    rv = mem_rvalid;
    a  = mem_addr;
    @(posedge clk);
    #1;
    if (rst) begin
      pend.delete();
    end else begin
      if (rv) void'(pend.pop_front());
      if (g) pend.push_back(a);
    end
    drive_mem();
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Runs a bounded number of cycles, dropping pc_ce once the offered PC is taken,
  // and records how many heads decode accepted and the first one's PC.
  task automatic run_until(input int budget, output int n, output logic [31:0] first);
    n     = 0;
    first = 32'hFFFF_FFFF;
    for (int i = 0; i < budget; i++) begin
      #1;
      if (id_valid && id_ready) begin
        if (n == 0) first = id_pc;
        n++;
      end
      if (pc_ce && !pc_stall) begin
        tick();
        pc_ce = 1'b0;
      end else begin
        tick();
      end
    end
  endtask

  initial begin
    logic acc;
    rst = 1'b1; pc = '0; pc_ce = 1'b0; flush = 1'b0; id_ready = 1'b0;
    gnt_en = 1'b1; ret_en = 1'b1;
    drive_mem();
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk1("rst_mem_req", mem_req, 1'b0);
    chk1("rst_pc_stall", pc_stall, 1'b0);
    chk1("rst_id_valid", id_valid, 1'b0);
    chk32("rst_id_inst", id_inst, 32'h0);
    chk32("rst_id_pc", id_pc, 32'h0);

    // Streaming: one PC per cycle, first delivery three cycles after acceptance.
    id_ready = 1'b1;
    pc_ce    = 1'b1;
    for (int k = 0; k < 8; k++) begin
      pc = 32'(4 * k);
      #1;
      chk1("stream_stall", pc_stall, 1'b0);
      if (k >= 3) begin
        chk1("stream_valid", id_valid, 1'b1);
        chk32("stream_pc", id_pc, 32'(4 * (k - 3)));
        chk32("stream_inst", id_inst, inst_of(32'(4 * (k - 3))));
      end
      tick();
    end
    pc_ce = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    #1;
    chk1("stream_drained", id_valid, 1'b0);
    chk1("stream_idle_req", mem_req, 1'b0);

    // Back-pressure: decode stalled, exactly four entries fit.
    id_ready = 1'b0;
    pc       = 32'h100;
    pc_ce    = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      acc = !pc_stall;
      tick();
      if (acc) pc = pc + 32'h4;
    end
    #1;
    chk32("bp_next_pc", pc, 32'h110);
    chk1("bp_stall", pc_stall, 1'b1);
    chk1("bp_no_req", mem_req, 1'b0);
    chk1("bp_valid", id_valid, 1'b1);
    pc_ce    = 1'b0;
    id_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk1("bp_drain_valid", id_valid, 1'b1);
      chk32("bp_drain_pc", id_pc, 32'h100 + 32'(4 * k));
      tick();
    end
    #1;
    chk1("bp_drain_empty", id_valid, 1'b0);

    // Slow grant: request held stable for three ungranted cycles.
    gnt_en = 1'b0;
    pc     = 32'h40;
    pc_ce  = 1'b1;
    #1;
    chk1("sg_accept", pc_stall, 1'b0);
    tick();
    pc = 32'h44;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk1("sg_req_held", mem_req, 1'b1);
      chk32("sg_addr_held", mem_addr, 32'h40);
      chk1("sg_stall", pc_stall, 1'b1);
      tick();
    end
    gnt_en = 1'b1;
    pc_ce  = 1'b0;
    #1;
    chk1("sg_gnt_req", mem_req, 1'b1);
    tick();
    #1;
    chk1("sg_not_yet", id_valid, 1'b0);
    tick();
    #1;
    chk1("sg_valid", id_valid, 1'b1);
    chk32("sg_pc", id_pc, 32'h40);
    chk32("sg_inst", id_inst, inst_of(32'h40));
    tick();
    #1;
    chk1("sg_single", id_valid, 1'b0);
    chk1("sg_idle", mem_req, 1'b0);

    // Flush with one queued entry and two granted-but-unreturned fetches.
    id_ready = 1'b0;
    pc = 32'h10; pc_ce = 1'b1;
    tick();
    pc_ce = 1'b0;
    tick();
    tick();
    ret_en = 1'b0;
    drive_mem();
    pc = 32'h20; pc_ce = 1'b1;
    tick();
    pc = 32'h24;
    tick();
    pc_ce = 1'b0;
    tick();
    #1;
    chk1("fl_pre_valid", id_valid, 1'b1);
    chk32("fl_pre_pc", id_pc, 32'h10);
    flush = 1'b1; pc = 32'h80; pc_ce = 1'b1; id_ready = 1'b1;
    #1;
    chk1("fl_stall", pc_stall, 1'b1);
    tick();
    flush  = 1'b0;
    ret_en = 1'b1;
    drive_mem();
    #1;
    chk1("fl_cleared", id_valid, 1'b0);
    run_until(12, n_del, first_pc);
    chk32("fl_count", 32'(n_del), 32'd1);
    chk32("fl_first_pc", first_pc, 32'h80);

    // Flush while a request to 0x30 is still ungranted.
    gnt_en = 1'b0;
    pc = 32'h30; pc_ce = 1'b1;
    tick();
    pc = 32'h90; flush = 1'b1;
    #1;
    chk1("fr_req", mem_req, 1'b1);
    chk32("fr_addr", mem_addr, 32'h30);
    chk1("fr_stall", pc_stall, 1'b1);
    tick();
    flush = 1'b0;
    #1;
    chk1("fr_req_kept", mem_req, 1'b1);
    chk32("fr_addr_kept", mem_addr, 32'h30);
    tick();
    gnt_en = 1'b1;
    run_until(12, n_del, first_pc);
    chk32("fr_count", 32'(n_del), 32'd1);
    chk32("fr_first_pc", first_pc, 32'h90);

    // Reset with three entries queued, then a clean restart.
    id_ready = 1'b0;
    pc = 32'h200; pc_ce = 1'b1;
    tick();
    pc = 32'h204;
    tick();
    pc = 32'h208;
    tick();
    pc_ce = 1'b0;
    tick();
    tick();
    #1;
    chk1("rs_pre_valid", id_valid, 1'b1);
    chk32("rs_pre_pc", id_pc, 32'h200);
    rst = 1'b1; pc = 32'h300; pc_ce = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk1("rs_valid", id_valid, 1'b0);
    chk1("rs_req", mem_req, 1'b0);
    chk1("rs_stall", pc_stall, 1'b0);
    chk32("rs_pc", id_pc, 32'h0);
    tick();
    pc_ce    = 1'b0;
    id_ready = 1'b1;
    tick();
    tick();
    #1;
    chk1("rs_restart_valid", id_valid, 1'b1);
    chk32("rs_restart_pc", id_pc, 32'h300);
    chk32("rs_restart_inst", id_inst, inst_of(32'h300));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
